// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, types and bit functions for the
// message scheduler and the compression pipeline.
package sha256_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [2:0] {
      LOAD,
      EXPAND,
      RUN,
      ACCUM,
      OUT
   } sched_state_e;

   localparam word_t K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [0:7][31:0] IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   function automatic word_t rotr(input word_t x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic word_t S0(input word_t x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic word_t S1(input word_t x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic word_t ch(input word_t e, input word_t f,
                                input word_t g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic word_t maj(input word_t a, input word_t b,
                                 input word_t c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

   function automatic word_t sig0(input word_t x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic word_t sig1(input word_t x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

endpackage

// File: rtl/sha256_expand_word.sv
// One step of the message schedule recurrence:
// W[t] = sig1(W[t-2]) + W[t-7] + sig0(W[t-15]) + W[t-16].
module sha256_expand_word
   import sha256_pkg::*;
(
   input  word_t i_w2,
   input  word_t i_w7,
   input  word_t i_w15,
   input  word_t i_w16,
   output word_t o_wt
);

   assign o_wt = sig1(i_w2) + i_w7 + sig0(i_w15) + i_w16;

endmodule

// File: rtl/sha256_msg_sched.sv
// Block loader, schedule expander and chaining-value keeper
// in front of the SHA-256 compression pipeline.
module sha256_msg_sched
   import sha256_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [31:0]       in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic [0:63][31:0] W_out,
   output logic [0:7][31:0]  H_core,
   output logic              core_rst,
   input  logic              core_done,
   input  logic [255:0]      core_H,
   output logic              digest_valid,
   output logic [255:0]      digest,
   input  logic              digest_ready
);

   sched_state_e      r_state;
   logic [3:0]        r_idx;
   logic [5:0]        r_t;
   logic              r_last;
   logic [0:63][31:0] r_w;
   logic [0:7][31:0]  r_h;
   logic              r_in_ready;
   logic              r_core_rst;
   logic              r_dval;

   word_t             w_wt;
   logic [0:7][31:0]  w_acc;

   sha256_expand_word u_expand (
      .i_w2  (r_w[r_t - 6'd2]),
      .i_w7  (r_w[r_t - 6'd7]),
      .i_w15 (r_w[r_t - 6'd15]),
      .i_w16 (r_w[r_t - 6'd16]),
      .o_wt  (w_wt)
   );

   // Per-word chaining add; no carry crosses word boundaries.
   always_comb begin
      w_acc = r_h;
      for (int i = 0; i < 8; i++) begin
         w_acc[i] = r_h[i] + core_H[255 - 32*i -: 32];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= LOAD;
         r_idx      <= 4'd0;
         r_t        <= 6'd16;
         r_last     <= 1'b0;
         r_w        <= '0;
         r_h        <= IV;
         r_in_ready <= 1'b1;
         r_core_rst <= 1'b1;
         r_dval     <= 1'b0;
      end else begin
         unique case (r_state)
            LOAD: begin
               if (in_valid && r_in_ready) begin
                  r_w[{2'b00, r_idx}] <= in_data;
                  r_idx <= r_idx + 4'd1;
                  if (r_idx == 4'd15) begin
                     r_last     <= in_last;
                     r_t        <= 6'd16;
                     r_in_ready <= 1'b0;
                     r_state    <= EXPAND;
                  end
               end
            end
            EXPAND: begin
               r_w[r_t] <= w_wt;
               r_t      <= r_t + 6'd1;
               if (r_t == 6'd63) begin
                  r_core_rst <= 1'b0;
                  r_state    <= RUN;
               end
            end
            RUN: begin
               if (core_done) begin
                  r_core_rst <= 1'b1;
                  r_state    <= ACCUM;
               end
            end
            ACCUM: begin
               r_h <= w_acc;
               if (r_last) begin
                  r_dval  <= 1'b1;
                  r_state <= OUT;
               end else begin
                  r_in_ready <= 1'b1;
                  r_state    <= LOAD;
               end
            end
            OUT: begin
               // A new message always restarts from the IV.
               if (digest_ready) begin
                  r_h        <= IV;
                  r_last     <= 1'b0;
                  r_dval     <= 1'b0;
                  r_in_ready <= 1'b1;
                  r_state    <= LOAD;
               end
            end
            default: begin
               r_state <= LOAD;
            end
         endcase
      end
   end

   assign in_ready     = r_in_ready;
   assign core_rst     = r_core_rst;
   assign digest_valid = r_dval;
   assign digest       = r_h;
   assign W_out        = r_w;
   assign H_core       = r_h;

endmodule
